// File: rtl/sram_chain_signature_monitor_pkg.sv
// Shared types and defaults for the SRAM clock-chain signature monitor:
// FSM state encoding, MISR default constants and the MISR step function.
package sram_chain_signature_monitor_pkg;

  localparam int          DATA_W_DEF = 8;
  localparam int          SIG_W_DEF  = 16;
  localparam logic [15:0] POLY_DEF   = 16'hB400;
  localparam logic [15:0] SEED_DEF   = 16'hFFFF;

  // Widest signature the step function handles; callers zero-extend into it.
  localparam int MISR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One Galois MISR step: shift right, fold in POLY when a 1 falls out of
  // the LSB, then XOR the (zero-extended) data word into the result.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [MISR_MAX_W-1:0] data
  );
    logic [MISR_MAX_W-1:0] shifted;
    shifted = sig >> 1;
    if (sig[0]) shifted = shifted ^ poly;
    return shifted ^ data;
  endfunction

endpackage

// File: rtl/sram_chain_signature_monitor_if.sv
// Bus between the chain-side driver (master) and the signature monitor
// (slave): run control, chain data word, expected signature and results.
interface sram_chain_signature_monitor_if #(
  parameter int DATA_W = 8,
  parameter int SIG_W  = 16
);

  logic              start;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic [SIG_W-1:0]  exp_sig;
  logic              busy;
  logic              done;
  logic              pass;
  logic [SIG_W-1:0]  signature;
  logic [7:0]        sample_cnt;
  logic [7:0]        stall_cnt;
  logic [15:0]       toggle_cnt;
  logic              timeout;

  modport master (
    output start, data_valid, data_in, exp_sig,
    input  busy, done, pass, signature, sample_cnt, stall_cnt, toggle_cnt, timeout
  );

  modport slave (
    input  start, data_valid, data_in, exp_sig,
    output busy, done, pass, signature, sample_cnt, stall_cnt, toggle_cnt, timeout
  );

endinterface

// File: rtl/sram_chain_misr.sv
// Signature register of the monitor: cleared by reset, loaded with SEED at
// the start of a run, and stepped once per accepted chain sample.
module sram_chain_misr
  import sram_chain_signature_monitor_pkg::*;
#(
  parameter int               DATA_W = DATA_W_DEF,
  parameter int               SIG_W  = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] data_in,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_step;

  assign sig_step = SIG_W'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(POLY),
                                     MISR_MAX_W'(data_in)));

  // Signature register: reset to zero, seed on load, advance on step.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // and does not appear in the sensitivity list.
    if (rst)       sig <= '0;
    else if (load) sig <= SEED;
    else if (step) sig <= sig_step;
  end

endmodule

// File: rtl/sram_chain_signature_monitor.sv
// Signature monitor for the SRAM clock-chain divider output. Compresses
// WINDOW valid chain words into a MISR signature, compares it with exp_sig,
// and counts stall cycles and bit toggles between accepted samples.
// Optional: define MISR_STALL_TIMEOUT_EN to abort a run into DONE with
// timeout=1 once STALL_LIMIT stall cycles accumulate in CAPTURE.
module sram_chain_signature_monitor
  import sram_chain_signature_monitor_pkg::*;
#(
  parameter int               DATA_W      = DATA_W_DEF,
  parameter int               SIG_W       = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY        = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED        = SIG_W'(SEED_DEF),
  parameter int               WINDOW      = 64,
  parameter int               STALL_LIMIT = 32
) (
  input logic                           clk,
  input logic                           rst,
  sram_chain_signature_monitor_if.slave bus
);

  localparam int         POP_W       = $clog2(DATA_W + 1);
  localparam logic [7:0] LAST_SAMPLE = 8'(WINDOW - 1);

  state_t            state_q, state_d;
  logic              load, accept, stall, compare, busy, done;
  logic              stall_expired;
  logic [SIG_W-1:0]  sig;
  logic [DATA_W-1:0] prev_q;
  logic [7:0]        sample_cnt_q, stall_cnt_q;
  logic [15:0]       toggle_cnt_q;
  logic              pass_q, timeout_q;
  logic [POP_W-1:0]  toggles;
  logic [16:0]       toggle_sum;

  function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] d);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_W; i++) cnt = cnt + POP_W'(d[i]);
    return cnt;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CAPTURE;
      CAPTURE: begin
        if (accept && sample_cnt_q == LAST_SAMPLE) state_d = COMPARE;
        else if (stall_expired)                   state_d = DONE;
      end
      COMPARE: state_d = DONE;
      DONE:    if (bus.start) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded controls; start only loads from IDLE or DONE.
  always_comb begin
    load    = 1'b0;
    accept  = 1'b0;
    stall   = 1'b0;
    compare = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:    load = bus.start;
      CAPTURE: begin
        busy   = 1'b1;
        accept = bus.data_valid;
        stall  = !bus.data_valid;
      end
      COMPARE: begin
        busy    = 1'b1;
        compare = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        load = bus.start;
      end
      default: ;
    endcase
  end

  sram_chain_misr #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (accept),
    .data_in (bus.data_in),
    .sig     (sig)
  );

  assign toggles    = popcount(bus.data_in ^ prev_q);
  assign toggle_sum = {1'b0, toggle_cnt_q} + 17'(toggles);

  // Run counters, previous-word register and registered compare result.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      sample_cnt_q <= '0;
      stall_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      prev_q       <= '0;
      pass_q       <= 1'b0;
    end else begin
      if (accept) begin
        sample_cnt_q <= sample_cnt_q + 8'd1;
        toggle_cnt_q <= toggle_sum[16] ? 16'hFFFF : toggle_sum[15:0];
        prev_q       <= bus.data_in;
      end
      if (stall && stall_cnt_q != 8'hFF) stall_cnt_q <= stall_cnt_q + 8'd1;
      if (compare) pass_q <= (sig == bus.exp_sig);
    end
  end

`ifdef MISR_STALL_TIMEOUT_EN
  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

  // The stall that brings stall_cnt to STALL_LIMIT ends the run.
  assign stall_expired = stall && (stall_cnt_q >= STALL_LAST);

  // Sticky timeout flag, cleared when a new run is loaded.
  always_ff @(posedge clk) begin
    if (rst || load)        timeout_q <= 1'b0;
    else if (stall_expired) timeout_q <= 1'b1;
  end
`else
  assign stall_expired = 1'b0;
  assign timeout_q     = 1'b0;
`endif

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass_q;
  assign bus.signature  = sig;
  assign bus.sample_cnt = sample_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.toggle_cnt = toggle_cnt_q;
  assign bus.timeout    = timeout_q;

endmodule
